// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
// Optional lock feature elsewhere is guarded by REG_ARB_LOCK_EN.
package reg_arb_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;
  localparam int MAX_NREQ  = 16;
  localparam int PTR_W     = $clog2(NREQ_DEF);

  // Callers truncate the result to their own requester count.
  function automatic logic [MAX_NREQ-1:0] onehot(input int unsigned idx);
    logic [MAX_NREQ-1:0] v;
    v = MAX_NREQ'(1) << idx;
    return v;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bus of the shared register arbiter.
// The lock signal exists only when REG_ARB_LOCK_EN is defined.
interface reg_write_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
);

  logic [NREQ-1:0]         req;
  logic [NREQ*WIDTH-1:0]   wdata;
`ifdef REG_ARB_LOCK_EN
  logic [NREQ-1:0]         lock;
`endif
  logic [NREQ-1:0]         gnt;
  logic [$clog2(NREQ)-1:0] owner;
  logic                    busy;
  logic [WIDTH-1:0]        q;
  logic [WIDTH-1:0]        qbar;

`ifdef REG_ARB_LOCK_EN
  modport master (output req, wdata, lock, input gnt, owner, busy, q, qbar);
  modport slave  (input req, wdata, lock, output gnt, owner, busy, q, qbar);
`else
  modport master (output req, wdata, input gnt, owner, busy, q, qbar);
  modport slave  (input req, wdata, output gnt, owner, busy, q, qbar);
`endif

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_priority_pick
  import reg_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  int unsigned idx;

  // Scan from the farthest offset down so the nearest request to ptr wins last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        winner = IW'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among NREQ writers.
// Define REG_ARB_LOCK_EN to let the owner hold the grant across writes.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  reg_write_arbiter_if.slave bus
);

  state_t            state, state_n;
  logic [IW-1:0]     ptr, ptr_n;
  logic [IW-1:0]     owner, owner_n;
  logic [NREQ-1:0]   gnt, gnt_n;
  logic [WIDTH-1:0]  q, q_n;
  logic [IW-1:0]     pick;
  logic              pick_valid;
  logic [IW-1:0]     ptr_adv;

  rr_priority_pick #(.NREQ(NREQ)) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .winner (pick),
    .valid  (pick_valid)
  );

  assign ptr_adv = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
      owner <= '0;
      gnt   <= '0;
      q     <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      gnt   <= gnt_n;
      q     <= q_n;
    end
  end

  // A dropped request in GRANT is a cancel: no write, but ptr still moves on.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    gnt_n   = gnt;
    q_n     = q;
    case (state)
      ST_IDLE: begin
        gnt_n = '0;
        if (pick_valid) begin
          state_n = ST_GRANT;
          owner_n = pick;
          gnt_n   = NREQ'(onehot(int'(pick)));
        end
      end
      ST_GRANT: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
        ptr_n   = ptr_adv;
        if (bus.req[owner]) begin
          q_n = bus.wdata[int'(owner)*WIDTH +: WIDTH];
`ifdef REG_ARB_LOCK_EN
          if (bus.lock[owner]) begin
            state_n = ST_GRANT;
            gnt_n   = gnt;
            ptr_n   = ptr;
          end
`endif
        end
      end
    endcase
  end

  assign bus.gnt   = gnt;
  assign bus.owner = owner;
  assign bus.busy  = (state == ST_GRANT);
  assign bus.q     = q;
  assign bus.qbar  = ~q;

endmodule
